k2_control_unit: RTL and testbench

//  Multi-cycle sequencer for the 8-bit K2 datapath (RA, RB, RO, ALU adder).

---
 rtl/k2_control_unit_if.sv | 31 +++
 rtl/k2_control_unit.sv | 107 ++++++++++
 tb/tb_k2_control_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/k2_control_unit_if.sv
// Bus between the K2 control unit and its environment (instruction ROM + datapath).
// The master side is the control unit.
interface k2_control_unit_if #(
  parameter int PC_W = 4
);
  logic            run;
  logic            imem_rd_en;
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      imem_rdata;
  logic            alu_carry;
  logic            ra_we;
  logic            rb_we;
  logic            ro_we;
  logic            src_imm;
  logic [3:0]      imm;
  logic            c_flag;
  logic            halted;
  logic            illegal;

  modport master (
    input  run, imem_rdata, alu_carry,
    output imem_rd_en, imem_addr, ra_we, rb_we, ro_we, src_imm, imm,
           c_flag, halted, illegal
  );

  modport slave (
    output run, imem_rdata, alu_carry,
    input  imem_rd_en, imem_addr, ra_we, rb_we, ro_we, src_imm, imm,
           c_flag, halted, illegal
  );
endinterface

// File: rtl/k2_control_unit.sv
// K2 sequencer: FETCH -> DECODE -> EXEC per instruction, owns PC, IR and carry flag.
// Datapath strobes are decoded from IR and are live only in EXEC.
module k2_control_unit #(
  parameter int              PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  k2_control_unit_if.master   bus
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDA = 4'h1;
  localparam logic [3:0] OP_ADDB = 4'h2;
  localparam logic [3:0] OP_LDA  = 4'h3;
  localparam logic [3:0] OP_LDB  = 4'h4;
  localparam logic [3:0] OP_OUT  = 4'h5;
  localparam logic [3:0] OP_J    = 4'h6;
  localparam logic [3:0] OP_JC   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'h8;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [7:0]      ir_q;
  logic            c_q;

  logic            rd_en;
  logic            ra_we, rb_we, ro_we, src_imm, illegal;
  logic            load_c, take_jump;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    ra_we     = 1'b0;
    rb_we     = 1'b0;
    ro_we     = 1'b0;
    src_imm   = 1'b0;
    illegal   = 1'b0;
    load_c    = 1'b0;
    take_jump = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.run) begin
          rd_en   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q[7:4])
          OP_NOP:  ;
          OP_ADDA: begin ra_we = 1'b1; load_c = 1'b1; end
          OP_ADDB: begin rb_we = 1'b1; load_c = 1'b1; end
          OP_LDA:  begin ra_we = 1'b1; src_imm = 1'b1; end
          OP_LDB:  begin rb_we = 1'b1; src_imm = 1'b1; end
          OP_OUT:  ro_we = 1'b1;
          OP_J:    take_jump = 1'b1;
          OP_JC:   take_jump = c_q;
          OP_HALT: state_d = S_HALTED;
          default: illegal = 1'b1;
        endcase
      end
      S_HALTED: ;
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        ir_q <= bus.imem_rdata;
        pc_q <= pc_q + PC_W'(1);
      end
      if (load_c)    c_q  <= bus.alu_carry;
      if (take_jump) pc_q <= PC_W'(ir_q[3:0]);
    end
  end

  // Reset leaves the FSM in FETCH; gating keeps the ROM enable quiet while reset is held.
  assign bus.imem_rd_en = rd_en & rst_n;
  assign bus.imem_addr  = pc_q;
  assign bus.ra_we      = ra_we;
  assign bus.rb_we      = rb_we;
  assign bus.ro_we      = ro_we;
  assign bus.src_imm    = src_imm;
  assign bus.imm        = ir_q[3:0];
  assign bus.c_flag     = c_q;
  assign bus.halted     = (state_q == S_HALTED);
  assign bus.illegal    = illegal;

endmodule

// File: tb/tb_k2_control_unit.sv
// Directed bench for k2_control_unit: sync ROM plus behavioural RA/RB/RO datapath.
// Expected values are hand-derived from the instruction sequences below.
module tb_k2_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  k2_control_unit_if #(.PC_W(4)) bus ();

  k2_control_unit #(.PC_W(4), .RESET_PC(4'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] rom [16];
  logic [7:0] rdata;
  logic [7:0] ra, rb, ro;
  logic [8:0] sum;
  logic       ovr_en = 1'b0;
  logic       ovr_val = 1'b0;
  logic [7:0] ro_log [$];

  int cyc = 0;
  int fetch_count;
  int last_fetch;
  bit have_last;
  int bad_spacing;
  bit chk_spacing = 1'b0;

  int checks = 0;
  int errors = 0;

  assign sum            = {1'b0, ra} + {1'b0, rb};
  assign bus.alu_carry  = ovr_en ? ovr_val : sum[8];
  assign bus.imem_rdata = rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= 8'h00;
    else if (bus.imem_rd_en) rdata <= rom[bus.imem_addr];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra <= 8'h00;
      rb <= 8'h00;
      ro <= 8'h00;
      ro_log.delete();
    end else begin
      if (bus.ra_we) ra <= bus.src_imm ? {4'h0, bus.imm} : sum[7:0];
      if (bus.rb_we) rb <= bus.src_imm ? {4'h0, bus.imm} : sum[7:0];
      if (bus.ro_we) begin
        ro <= ra;
        ro_log.push_back(ra);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 0;
      have_last   <= 1'b0;
      last_fetch  <= 0;
      bad_spacing <= 0;
    end else if (bus.imem_rd_en) begin
      fetch_count <= fetch_count + 1;
      if (chk_spacing && have_last && (cyc - last_fetch != 3))
        bad_spacing <= bad_spacing + 1;
      last_fetch <= cyc;
      have_last  <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.run = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic release_reset();
    tick(2);
    rst_n   = 1'b1;
    bus.run = 1'b1;
    #1;
  endtask

  initial begin
    bus.run = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;

    // ---- 1: reset state and reset during EXEC of ADDA
    tick(2);
    check("rst_rd_en",  32'(bus.imem_rd_en), 32'd0);
    check("rst_addr",   32'(bus.imem_addr),  32'd0);
    check("rst_strobe", 32'({bus.ra_we, bus.rb_we, bus.ro_we, bus.src_imm}), 32'd0);
    check("rst_status", 32'({bus.c_flag, bus.halted, bus.illegal}), 32'd0);
    check("rst_imm",    32'(bus.imm), 32'd0);

    hold_reset();
    rom[0] = 8'h11; rom[1] = 8'h11;
    ovr_en = 1'b1; ovr_val = 1'b1;
    release_reset();
    check("rel_rd_en", 32'(bus.imem_rd_en), 32'd1);
    check("rel_addr",  32'(bus.imem_addr),  32'd0);
    tick(5);
    check("adda_ra_we", 32'(bus.ra_we),     32'd1);
    check("adda_c",     32'(bus.c_flag),    32'd1);
    check("adda_pc",    32'(bus.imem_addr), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_ra_we", 32'(bus.ra_we),     32'd0);
    check("midrst_pc",    32'(bus.imem_addr), 32'd0);
    check("midrst_c",     32'(bus.c_flag),    32'd0);
    check("midrst_rd_en", 32'(bus.imem_rd_en), 32'd0);
    tick(1);
    rst_n = 1'b1;
    #1;
    check("rerel_rd_en", 32'(bus.imem_rd_en), 32'd1);
    check("rerel_addr",  32'(bus.imem_addr),  32'd0);

    // ---- 2: Fibonacci loop, exits via JC on the first carry
    hold_reset();
    ovr_en = 1'b0;
    rom[0] = 8'h30; rom[1] = 8'h41; rom[2] = 8'h50; rom[3] = 8'h11;
    rom[4] = 8'h50; rom[5] = 8'h21; rom[6] = 8'h78; rom[7] = 8'h63;
    rom[8] = 8'h80;
    chk_spacing = 1'b1;
    release_reset();
    for (int i = 0; i < 400 && !bus.halted; i++) @(negedge clk);
    #1;
    chk_spacing = 1'b0;
    check("fib_halted", 32'(bus.halted), 32'd1);
    check("fib_ro_count", 32'(ro_log.size()), 32'd8);
    begin
      logic [7:0] fib_exp [8];
      fib_exp = '{8'd0, 8'd1, 8'd3, 8'd8, 8'd21, 8'd55, 8'd144, 8'd121};
      for (int i = 0; i < 8; i++)
        check($sformatf("fib_ro%0d", i), 32'(i < ro_log.size() ? ro_log[i] : 8'hxx), 32'(fib_exp[i]));
    end
    check("fib_rb",      32'(rb),             32'd98);
    check("fib_c",       32'(bus.c_flag),     32'd1);
    check("fib_fetches", 32'(fetch_count),    32'd38);
    check("fib_spacing", 32'(bad_spacing),    32'd0);
    check("fib_pc",      32'(bus.imem_addr),  32'd9);

    // ---- 3: JC taken / not taken
    hold_reset();
    rom[0] = 8'h11; rom[1] = 8'h75;
    ovr_en = 1'b1; ovr_val = 1'b1;
    release_reset();
    tick(6);
    check("jc_taken_addr", 32'(bus.imem_addr), 32'd5);
    check("jc_taken_c",    32'(bus.c_flag),    32'd1);

    hold_reset();
    rom[0] = 8'h11; rom[1] = 8'h75;
    ovr_val = 1'b0;
    release_reset();
    tick(6);
    check("jc_fall_addr", 32'(bus.imem_addr), 32'd2);
    check("jc_fall_c",    32'(bus.c_flag),    32'd0);

    // ---- 4: PC wrap 15 -> 0
    hold_reset();
    ovr_en = 1'b0;
    rom[0] = 8'h6F; rom[15] = 8'h00;
    release_reset();
    tick(3);
    check("j_addr",    32'(bus.imem_addr), 32'd15);
    tick(3);
    check("wrap_addr", 32'(bus.imem_addr), 32'd0);
    check("wrap_c",    32'(bus.c_flag),    32'd0);

    // ---- 5: stall after fetch, resume at PC
    hold_reset();
    rom[0] = 8'h37; rom[1] = 8'h50;
    release_reset();
    tick(1);
    bus.run = 1'b0;
    tick(1);
    check("stall_exec", 32'({bus.ra_we, bus.src_imm, bus.imm}), 32'h37);
    tick(1);
    check("stall_rd_en", 32'(bus.imem_rd_en), 32'd0);
    check("stall_addr",  32'(bus.imem_addr),  32'd1);
    tick(6);
    check("stall_hold",    32'(bus.imem_rd_en), 32'd0);
    check("stall_fetches", 32'(fetch_count),    32'd1);
    check("stall_ra",      32'(ra),             32'd7);
    bus.run = 1'b1;
    #1;
    check("resume_rd_en", 32'(bus.imem_rd_en), 32'd1);
    check("resume_addr",  32'(bus.imem_addr),  32'd1);
    tick(2);
    check("resume_out", 32'(bus.ro_we), 32'd1);
    tick(1);
    check("resume_ro",  32'(ro), 32'd7);

    // ---- 6: illegal opcode then HALT
    hold_reset();
    rom[0] = 8'h11; rom[1] = 8'hA3; rom[2] = 8'h80; rom[3] = 8'h30;
    ovr_en = 1'b1; ovr_val = 1'b1;
    release_reset();
    tick(5);
    check("ill_pulse",   32'(bus.illegal), 32'd1);
    check("ill_strobes", 32'({bus.ra_we, bus.rb_we, bus.ro_we}), 32'd0);
    check("ill_imm",     32'(bus.imm),     32'd3);
    ovr_val = 1'b0;
    tick(1);
    check("ill_clear", 32'(bus.illegal), 32'd0);
    check("ill_c",     32'(bus.c_flag),  32'd1);
    tick(2);
    check("halt_exec", 32'({bus.halted, bus.ra_we, bus.rb_we, bus.ro_we}), 32'd0);
    tick(1);
    check("halted",       32'(bus.halted),     32'd1);
    check("halted_rd_en", 32'(bus.imem_rd_en), 32'd0);
    tick(20);
    check("halted_hold",    32'({bus.halted, bus.imem_rd_en}), 32'b10);
    check("halted_fetches", 32'(fetch_count),  32'd3);
    check("halted_c",       32'(bus.c_flag),   32'd1);
    rst_n = 1'b0;
    #1;
    check("halt_rst", 32'(bus.halted), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
